// File: rtl/cbus_pkg.sv
// Shared definitions for the configuration-bus host master and its select stage.
// Latency: n/a (package only).
// Backpressure: n/a. Provides FSM state encodings, default widths and default error data.
package cbus_pkg;

    localparam int CBUS_DW = 32;
    localparam int CBUS_AW = 16;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_ABORT    = 3'd4
    } cbus_state_t;

endpackage

// File: rtl/cbus_host_master_if.sv
// Host request/response port plus cbus slave-side signals of the select stage.
// Latency: n/a (wiring only).
// Backpressure: host_req_* is valid/ready; host_rsp_* is a strobe with no backpressure.
// Modport master = host master block; modport slave = host plus select stage (environment).
interface cbus_host_master_if #(
    parameter int DW = cbus_pkg::CBUS_DW,
    parameter int AW = cbus_pkg::CBUS_AW
);
    logic          host_req_valid;
    logic          host_req_ready;
    logic          host_req_wr;
    logic [AW-1:0] host_req_addr;
    logic [DW-1:0] host_req_wdata;
    logic          host_rsp_valid;
    logic [DW-1:0] host_rsp_rdata;
    logic          host_rsp_err;

    logic [AW-1:0] cbus_slv_address;
    logic          cbus_slv_cfg_req;
    logic          cbus_slv_cmd;
    logic [DW-1:0] cbus_slv_wdata;
    logic          cbus_slv_waccept;
    logic          cbus_slv_rresp;
    logic [DW-1:0] cbus_slv_rdatap;

    modport master (
        input  host_req_valid, host_req_wr, host_req_addr, host_req_wdata,
        output host_req_ready, host_rsp_valid, host_rsp_rdata, host_rsp_err,
        output cbus_slv_address, cbus_slv_cfg_req, cbus_slv_cmd, cbus_slv_wdata,
        input  cbus_slv_waccept, cbus_slv_rresp, cbus_slv_rdatap
    );

    modport slave (
        output host_req_valid, host_req_wr, host_req_addr, host_req_wdata,
        input  host_req_ready, host_rsp_valid, host_rsp_rdata, host_rsp_err,
        input  cbus_slv_address, cbus_slv_cfg_req, cbus_slv_cmd, cbus_slv_wdata,
        output cbus_slv_waccept, cbus_slv_rresp, cbus_slv_rdatap
    );

endinterface

// File: rtl/cbus_tmo_cnt.sv
// Saturating ack-wait counter with clear/enable; flags the last allowed wait cycle.
// Latency: count updates one cycle after clr/en; expired is combinational from count.
// Backpressure: none. Ports: clk, reset, clr, en, limit in; expired out (limit 0 = never).
module cbus_tmo_cnt #(
    parameter int WID = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clr,
    input  logic           en,
    input  logic [WID-1:0] limit,
    output logic           expired
);

    logic [WID-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != '1)) begin
            count_q <= count_q + WID'(1);
        end
    end

    // Count starts at 0 in the first wait cycle, so limit-1 marks the final one.
    assign expired = (limit != '0) && (count_q == (limit - WID'(1)));

endmodule

// File: rtl/cbus_host_master.sv
// Host-side cbus master: one register read/write at a time, address setup, ack wait, timeout.
// Latency: handshake to response strobe = 3 + ack wait cycles; timeout response at tmo_limit+1.
// Backpressure: host_req_ready low from handshake until back in IDLE; responses never stall.
// Ports: clk, reset, tmo_limit, abort_pending, bus (host port + cbus slave signals, master modport).
module cbus_host_master
    import cbus_pkg::*;
#(
    parameter int             DW       = CBUS_DW,
    parameter int             AW       = CBUS_AW,
    parameter int             TIM_WID  = 8,
    parameter logic [DW-1:0]  ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [TIM_WID-1:0] tmo_limit,
    output logic               abort_pending,
    cbus_host_master_if.master bus
);

    cbus_state_t   state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          cmd_q, cmd_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          cfg_req_q, cfg_req_d;
    logic          ready_q, ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic          abort_q, abort_d;
    logic          ack;
    logic          cnt_clr;
    logic          cnt_en;
    logic          expired;

    assign ack = bus.cbus_slv_waccept | bus.cbus_slv_rresp;

    cbus_tmo_cnt #(.WID(TIM_WID)) u_tmo_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .limit   (tmo_limit),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cmd_q       <= 1'b0;
            wdata_q     <= '0;
            cfg_req_q   <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cmd_q       <= cmd_d;
            wdata_q     <= wdata_d;
            cfg_req_q   <= cfg_req_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            abort_q     <= abort_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cmd_d       = cmd_q;
        wdata_d     = wdata_q;
        cfg_req_d   = cfg_req_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        abort_d     = abort_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (bus.host_req_valid && ready_q) begin
                    addr_d  = bus.host_req_addr;
                    cmd_d   = bus.host_req_wr;
                    wdata_d = bus.host_req_wdata;
                    ready_d = 1'b0;
                    state_d = ST_SETUP;
                end
            end
            // Address has been on the bus for one cycle before cfg_req rises, so the
            // select stage decodes the unit index before any chip-select goes high.
            ST_SETUP: begin
                cnt_clr   = 1'b1;
                cfg_req_d = 1'b1;
                state_d   = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                cnt_en = 1'b1;
                // Ack takes priority over a timeout expiring in the same cycle.
                if (ack) begin
                    cfg_req_d = 1'b0;
                    state_d   = ST_CAPTURE;
                end else if (expired) begin
                    cfg_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = cmd_q ? '0 : ERR_DATA;
                    abort_d     = 1'b1;
                    state_d     = ST_ABORT;
                end
            end
            // Read data is valid the cycle after ack; register it with the strobe.
            ST_CAPTURE: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = cmd_q ? '0 : bus.cbus_slv_rdatap;
                ready_d     = 1'b1;
                state_d     = ST_IDLE;
            end
            // The unit's chip-select stays up until it acks; swallow that late ack.
            ST_ABORT: begin
                if (ack) begin
                    abort_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cfg_req_d = 1'b0;
                abort_d   = 1'b0;
                ready_d   = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    assign bus.host_req_ready   = ready_q;
    assign bus.host_rsp_valid   = rsp_valid_q;
    assign bus.host_rsp_rdata   = rsp_rdata_q;
    assign bus.host_rsp_err     = rsp_err_q;
    assign bus.cbus_slv_address = addr_q;
    assign bus.cbus_slv_cfg_req = cfg_req_q;
    assign bus.cbus_slv_cmd     = cmd_q;
    assign bus.cbus_slv_wdata   = wdata_q;
    assign abort_pending        = abort_q;

endmodule

// File: tb/tb_cbus_host_master.sv
// Directed self-checking bench for cbus_host_master: reset, write, read, timeout,
// ack/timeout race, reset mid-transfer, and 8 back-to-back requests.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_cbus_host_master;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [TW-1:0] tmo_limit;
    logic          abort_pending;
    int            checks = 0;
    int            passed = 0;

    cbus_host_master_if #(.DW(DW), .AW(AW)) bus();

    cbus_host_master #(
        .DW(DW), .AW(AW), .TIM_WID(TW), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tmo_limit     (tmo_limit),
        .abort_pending (abort_pending),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.host_req_valid   = 1'b0;
        bus.host_req_wr      = 1'b0;
        bus.host_req_addr    = '0;
        bus.host_req_wdata   = '0;
        bus.cbus_slv_waccept = 1'b0;
        bus.cbus_slv_rresp   = 1'b0;
        bus.cbus_slv_rdatap  = '0;
    endtask

    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.host_req_valid = 1'b1;
        bus.host_req_wr    = wr;
        bus.host_req_addr  = a;
        bus.host_req_wdata = d;
    endtask

    task automatic test_reset();
        idle_inputs();
        tmo_limit = '0;
        reset = 1'b1;
        tick();
        tick();
        checks++; if (bus.host_req_ready !== 1'b1) $display("FAIL reset_ready got %0h want 1", bus.host_req_ready); else passed++;
        checks++; if (bus.cbus_slv_cfg_req !== 1'b0) $display("FAIL reset_cfg_req got %0h want 0", bus.cbus_slv_cfg_req); else passed++;
        checks++; if (bus.host_rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %0h want 0", bus.host_rsp_valid); else passed++;
        checks++; if (abort_pending !== 1'b0) $display("FAIL reset_abort got %0h want 0", abort_pending); else passed++;
        checks++; if (bus.cbus_slv_address !== 16'h0) $display("FAIL reset_address got %0h want 0", bus.cbus_slv_address); else passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write();
        tmo_limit = 8'd0;
        send(1'b1, 16'h2004, 32'hA5A5_0001);
        tick();  // handshake edge E0
        bus.host_req_valid = 1'b0;
        checks++; if (bus.cbus_slv_address !== 16'h2004) $display("FAIL wr_addr_e0 got %0h want 2004", bus.cbus_slv_address); else passed++;
        checks++; if (bus.cbus_slv_cfg_req !== 1'b0) $display("FAIL wr_setup_cfg_req got %0h want 0", bus.cbus_slv_cfg_req); else passed++;
        checks++; if (bus.cbus_slv_cmd !== 1'b1 || bus.cbus_slv_wdata !== 32'hA5A5_0001) $display("FAIL wr_cmd_wdata got %0h/%0h want 1/a5a50001", bus.cbus_slv_cmd, bus.cbus_slv_wdata); else passed++;
        checks++; if (bus.host_req_ready !== 1'b0) $display("FAIL wr_ready_busy got %0h want 0", bus.host_req_ready); else passed++;
        for (int k = 0; k < 3; k++) begin
            tick();  // E1..E3: cfg_req high, address stable
            checks++; if (bus.cbus_slv_cfg_req !== 1'b1) $display("FAIL wr_cfg_req_hold%0d got %0h want 1", k, bus.cbus_slv_cfg_req); else passed++;
            checks++; if (bus.cbus_slv_address !== 16'h2004) $display("FAIL wr_addr_hold%0d got %0h want 2004", k, bus.cbus_slv_address); else passed++;
            checks++; if (bus.host_rsp_valid !== 1'b0) $display("FAIL wr_early_rsp%0d got %0h want 0", k, bus.host_rsp_valid); else passed++;
        end
        bus.cbus_slv_waccept = 1'b1;  // ack two cycles after cfg_req rose
        tick();
        bus.cbus_slv_waccept = 1'b0;
        bus.cbus_slv_rdatap  = 32'hFFFF_FFFF;
        checks++; if (bus.cbus_slv_cfg_req !== 1'b0) $display("FAIL wr_cfg_req_drop got %0h want 0", bus.cbus_slv_cfg_req); else passed++;
        checks++; if (bus.host_rsp_valid !== 1'b0) $display("FAIL wr_capture_rsp got %0h want 0", bus.host_rsp_valid); else passed++;
        tick();
        bus.cbus_slv_rdatap = '0;
        checks++; if (bus.host_rsp_valid !== 1'b1) $display("FAIL wr_rsp_valid got %0h want 1", bus.host_rsp_valid); else passed++;
        checks++; if (bus.host_rsp_err !== 1'b0 || bus.host_rsp_rdata !== 32'h0) $display("FAIL wr_rsp_data got err %0h data %0h want 0/0", bus.host_rsp_err, bus.host_rsp_rdata); else passed++;
        checks++; if (bus.host_req_ready !== 1'b1) $display("FAIL wr_ready_back got %0h want 1", bus.host_req_ready); else passed++;
        tick();
        checks++; if (bus.host_rsp_valid !== 1'b0) $display("FAIL wr_single_rsp got %0h want 0", bus.host_rsp_valid); else passed++;
    endtask

    task automatic test_read();
        tmo_limit = 8'd0;
        send(1'b0, 16'hE010, 32'h0);
        tick();  // E0
        bus.host_req_valid = 1'b0;
        tick();  // E1: first WAIT_ACK cycle
        checks++; if (bus.cbus_slv_cfg_req !== 1'b1) $display("FAIL rd_cfg_req got %0h want 1", bus.cbus_slv_cfg_req); else passed++;
        bus.cbus_slv_rresp = 1'b1;
        tick();  // E2: ack taken
        bus.cbus_slv_rresp  = 1'b0;
        bus.cbus_slv_rdatap = 32'h1234_5678;
        checks++; if (bus.cbus_slv_cfg_req !== 1'b0) $display("FAIL rd_cfg_req_drop got %0h want 0", bus.cbus_slv_cfg_req); else passed++;
        checks++; if (bus.host_rsp_valid !== 1'b0) $display("FAIL rd_capture_rsp got %0h want 0", bus.host_rsp_valid); else passed++;
        tick();  // E3: response three cycles after handshake
        bus.cbus_slv_rdatap = '0;
        checks++; if (bus.host_rsp_valid !== 1'b1) $display("FAIL rd_rsp_valid got %0h want 1", bus.host_rsp_valid); else passed++;
        checks++; if (bus.host_rsp_rdata !== 32'h1234_5678) $display("FAIL rd_rdata got %0h want 12345678", bus.host_rsp_rdata); else passed++;
        checks++; if (bus.host_rsp_err !== 1'b0) $display("FAIL rd_err got %0h want 0", bus.host_rsp_err); else passed++;
        tick();
    endtask

    task automatic test_timeout();
        tmo_limit = 8'd4;
        send(1'b0, 16'h1000, 32'h0);
        tick();  // E0
        bus.host_req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (bus.host_rsp_valid !== 1'b0) $display("FAIL tmo_early_rsp%0d got %0h want 0", k, bus.host_rsp_valid); else passed++;
        end
        tick();  // E5
        checks++; if (bus.host_rsp_valid !== 1'b1) $display("FAIL tmo_rsp_valid got %0h want 1", bus.host_rsp_valid); else passed++;
        checks++; if (bus.host_rsp_err !== 1'b1) $display("FAIL tmo_err got %0h want 1", bus.host_rsp_err); else passed++;
        checks++; if (bus.host_rsp_rdata !== 32'hDEAD_BEEF) $display("FAIL tmo_rdata got %0h want deadbeef", bus.host_rsp_rdata); else passed++;
        checks++; if (bus.cbus_slv_cfg_req !== 1'b0) $display("FAIL tmo_cfg_req got %0h want 0", bus.cbus_slv_cfg_req); else passed++;
        send(1'b1, 16'h7777, 32'h1);  // must not be accepted while aborting
        for (int k = 0; k < 3; k++) begin
            checks++; if (abort_pending !== 1'b1 || bus.host_req_ready !== 1'b0) $display("FAIL tmo_abort_hold%0d got abort %0h ready %0h want 1/0", k, abort_pending, bus.host_req_ready); else passed++;
            tick();
            checks++; if (bus.host_rsp_valid !== 1'b0) $display("FAIL tmo_extra_rsp%0d got %0h want 0", k, bus.host_rsp_valid); else passed++;
        end
        bus.host_req_valid   = 1'b0;
        bus.cbus_slv_waccept = 1'b1;  // late ack
        tick();
        bus.cbus_slv_waccept = 1'b0;
        checks++; if (abort_pending !== 1'b0 || bus.host_req_ready !== 1'b1) $display("FAIL tmo_abort_exit got abort %0h ready %0h want 0/1", abort_pending, bus.host_req_ready); else passed++;
        checks++; if (bus.host_rsp_valid !== 1'b0) $display("FAIL tmo_late_ack_rsp got %0h want 0", bus.host_rsp_valid); else passed++;
        tick();
        checks++; if (bus.host_rsp_valid !== 1'b0) $display("FAIL tmo_second_rsp got %0h want 0", bus.host_rsp_valid); else passed++;
    endtask

    task automatic test_race();
        tmo_limit = 8'd3;
        send(1'b0, 16'h3008, 32'h0);
        tick();  // E0
        bus.host_req_valid = 1'b0;
        tick();  // count 0
        tick();  // count 1
        tick();  // count 2 = expiry cycle
        bus.cbus_slv_rresp = 1'b1;
        tick();
        bus.cbus_slv_rresp  = 1'b0;
        bus.cbus_slv_rdatap = 32'hCAFE_0003;
        checks++; if (bus.host_rsp_valid !== 1'b0 || abort_pending !== 1'b0) $display("FAIL race_no_abort got rsp %0h abort %0h want 0/0", bus.host_rsp_valid, abort_pending); else passed++;
        tick();
        bus.cbus_slv_rdatap = '0;
        checks++; if (bus.host_rsp_valid !== 1'b1 || bus.host_rsp_err !== 1'b0) $display("FAIL race_rsp got valid %0h err %0h want 1/0", bus.host_rsp_valid, bus.host_rsp_err); else passed++;
        checks++; if (bus.host_rsp_rdata !== 32'hCAFE_0003) $display("FAIL race_rdata got %0h want cafe0003", bus.host_rsp_rdata); else passed++;
        tick();
        checks++; if (bus.host_req_ready !== 1'b1 || abort_pending !== 1'b0) $display("FAIL race_idle got ready %0h abort %0h want 1/0", bus.host_req_ready, abort_pending); else passed++;
    endtask

    task automatic test_reset_mid();
        tmo_limit = 8'd0;
        send(1'b1, 16'h5550, 32'h0000_0001);
        tick();
        bus.host_req_valid = 1'b0;
        tick();
        tick();
        checks++; if (bus.cbus_slv_cfg_req !== 1'b1) $display("FAIL rst_pre_cfg_req got %0h want 1", bus.cbus_slv_cfg_req); else passed++;
        reset = 1'b1;
        #1;
        checks++; if (bus.cbus_slv_cfg_req !== 1'b0) $display("FAIL rst_cfg_req got %0h want 0", bus.cbus_slv_cfg_req); else passed++;
        checks++; if (bus.host_req_ready !== 1'b1) $display("FAIL rst_ready got %0h want 1", bus.host_req_ready); else passed++;
        checks++; if (bus.host_rsp_valid !== 1'b0 || abort_pending !== 1'b0) $display("FAIL rst_rsp_abort got %0h/%0h want 0/0", bus.host_rsp_valid, abort_pending); else passed++;
        tick();
        reset = 1'b0;
        // Stray acks while idle must not produce anything.
        bus.cbus_slv_waccept = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (bus.host_rsp_valid !== 1'b0 || bus.cbus_slv_cfg_req !== 1'b0) $display("FAIL idle_ack%0d got rsp %0h cfg_req %0h want 0/0", k, bus.host_rsp_valid, bus.cbus_slv_cfg_req); else passed++;
        end
        bus.cbus_slv_waccept = 1'b0;
        // Reset while aborting clears abort_pending at once.
        tmo_limit = 8'd2;
        send(1'b0, 16'h6000, 32'h0);
        tick();
        bus.host_req_valid = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (abort_pending !== 1'b1) $display("FAIL rst_abort_pre got %0h want 1", abort_pending); else passed++;
        reset = 1'b1;
        #1;
        checks++; if (abort_pending !== 1'b0 || bus.host_req_ready !== 1'b1) $display("FAIL rst_abort got abort %0h ready %0h want 0/1", abort_pending, bus.host_req_ready); else passed++;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a[8];
        logic          w[8];
        logic [DW-1:0] wd[8];
        int            dly[8];
        int            hs_cyc[8];
        int            req_idx = 0;
        int            n_rsp = 0;
        int            cyc = 0;
        int            hi_cnt = 0;
        bit            ack_prev = 1'b0;
        bit            hs_now;
        logic [DW-1:0] exp_data;

        for (int i = 0; i < 8; i++) begin
            a[i]   = 16'h4000 + 16'(i * 4);
            w[i]   = (i % 2) == 1;
            wd[i]  = 32'h1000_0000 + 32'(i);
            dly[i] = i % 3;
        end
        tmo_limit = 8'd0;
        send(w[0], a[0], wd[0]);
        hs_now = bus.host_req_ready;

        while (n_rsp < 8 && cyc < 300) begin
            tick();
            cyc++;
            if (hs_now) begin
                hs_cyc[req_idx] = cyc;
                checks++; if (bus.cbus_slv_cfg_req !== 1'b0) $display("FAIL b2b_setup_cfg_req%0d got %0h want 0", req_idx, bus.cbus_slv_cfg_req); else passed++;
                checks++; if (bus.cbus_slv_address !== a[req_idx]) $display("FAIL b2b_addr%0d got %0h want %0h", req_idx, bus.cbus_slv_address, a[req_idx]); else passed++;
                if (req_idx > 0) begin
                    checks++; if (hs_cyc[req_idx] !== hs_cyc[req_idx-1] + 4 + dly[req_idx-1]) $display("FAIL b2b_turnaround%0d got %0d want %0d", req_idx, hs_cyc[req_idx], hs_cyc[req_idx-1] + 4 + dly[req_idx-1]); else passed++;
                end
                req_idx++;
            end
            if (bus.host_rsp_valid) begin
                exp_data = w[n_rsp] ? 32'h0 : {16'hB0B0, a[n_rsp]};
                checks++; if (bus.host_rsp_rdata !== exp_data || bus.host_rsp_err !== 1'b0) $display("FAIL b2b_rsp%0d got %0h err %0h want %0h err 0", n_rsp, bus.host_rsp_rdata, bus.host_rsp_err, exp_data); else passed++;
                checks++; if (cyc !== hs_cyc[n_rsp] + 3 + dly[n_rsp]) $display("FAIL b2b_latency%0d got %0d want %0d", n_rsp, cyc, hs_cyc[n_rsp] + 3 + dly[n_rsp]); else passed++;
                n_rsp++;
            end
            // Unit model: ack after dly cycles of cfg_req, data on the following cycle.
            bus.cbus_slv_rdatap  = (ack_prev && n_rsp < 8) ? {16'hB0B0, a[n_rsp]} : 32'h0;
            ack_prev             = 1'b0;
            bus.cbus_slv_waccept = 1'b0;
            bus.cbus_slv_rresp   = 1'b0;
            if (bus.cbus_slv_cfg_req && n_rsp < 8) begin
                if (hi_cnt == dly[n_rsp]) begin
                    if (w[n_rsp]) bus.cbus_slv_waccept = 1'b1;
                    else          bus.cbus_slv_rresp   = 1'b1;
                    ack_prev = 1'b1;
                end
                hi_cnt++;
            end else begin
                hi_cnt = 0;
            end
            if (req_idx < 8) send(w[req_idx], a[req_idx], wd[req_idx]);
            else             bus.host_req_valid = 1'b0;
            hs_now = bus.host_req_valid && bus.host_req_ready;
        end
        idle_inputs();
        checks++; if (n_rsp !== 8) $display("FAIL b2b_count got %0d want 8 (cycle budget %0d)", n_rsp, cyc); else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_race();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
